blk_sched: RTL and testbench

//   Sequencer for the per-block luminance accumulator: turns raw video timing (vs/de) into
//   the h_save / v_save strobes the accumulator consumes.

---
 rtl/blk_pkg.sv | 30 +++
 rtl/blk_wrap_cnt.sv | 29 ++
 rtl/blk_sched.sv | 210 +++++++++++++++++++++
 tb/tb_blk_sched.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blk_pkg.sv
// Shared constants and FSM encoding for the block scheduler.
// The width constants describe the default build (10x10 blocks of 30x30
// pixels); modules that take their own block geometry as parameters derive
// their widths with clog2_min1 so single-value counters still get one bit.
package blk_pkg;

  localparam int HBLKS_DEF = 10;
  localparam int VBLKS_DEF = 10;
  localparam int BLK_W_DEF = 30;
  localparam int BLK_H_DEF = 30;

  localparam int PX_W = $clog2(BLK_W_DEF);
  localparam int BX_W = $clog2(HBLKS_DEF + 1);
  localparam int LN_W = $clog2(BLK_H_DEF);
  localparam int BY_W = $clog2(VBLKS_DEF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // ceil(log2(v)) but never less than one bit
  function automatic int clog2_min1(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/blk_wrap_cnt.sv
// Modulo-MAX counter used for the pixel, block, line and block-row counts.
// clr has priority over en; wrap is high in the cycle the count rolls from
// MAX-1 back to 0, so it can directly enable the next counter in the chain.
module blk_wrap_cnt
  import blk_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = clog2_min1(MAX)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         wrap
);

  assign wrap = en && (q == W'(MAX - 1));

  // count register: clear, then advance/wrap on enable
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      q <= '0;
    end else if (en) begin
      q <= wrap ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/blk_sched.sv
// Block scheduler: derives h_save / v_save / frame_done strobes from vs/de
// timing and delays the pixel stream by one cycle so each h_save_o lands on
// the last pixel of its block as seen on de_o/wd_o.
// Optional feature macro: BLK_SCHED_ERR_EN enables the sticky err_o timing
// check (bad line length, or vs edge in the middle of a frame). Without it
// err_o is tied low.
// This is a streaming block with no backpressure: every de_i cycle is a
// pixel that must be consumed, so there is no valid/ready handshake.
// dbg_state_o exposes the FSM state for observation.
module blk_sched
  import blk_pkg::*;
#(
  parameter int  HBLKS = 10,
  parameter int  VBLKS = 10,
  parameter int  BLK_W = 30,
  parameter int  BLK_H = 30,
  localparam int XO_W  = clog2_min1(HBLKS),
  localparam int YO_W  = clog2_min1(VBLKS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            vs_i,
  input  logic            de_i,
  input  logic [23:0]     wd_i,
  output logic            de_o,
  output logic [23:0]     wd_o,
  output logic            h_save_o,
  output logic            v_save_o,
  output logic [XO_W-1:0] blk_x_o,
  output logic [YO_W-1:0] blk_y_o,
  output logic            frame_done_o,
  output logic            err_o,
  output logic [1:0]      dbg_state_o
);

  localparam int PXW = clog2_min1(BLK_W);
  localparam int BXW = clog2_min1(HBLKS + 1);
  localparam int LNW = clog2_min1(BLK_H);
  localparam int BYW = YO_W;

  state_t state_q, state_d;

  logic           vs_q;
  logic           vs_rise, de_rise, de_fall;
  logic           active;
  logic           line_ok_q;
  logic           line_live;
  logic           px_en, px_wrap;
  logic           ln_en, ln_wrap, by_wrap, bx_wrap;
  logic           bx_room;
  logic           v_hit, f_hit;
  logic           v_pend_q, f_pend_q;
  logic [PXW-1:0] px_q;
  logic [BXW-1:0] bx_q;
  logic [LNW-1:0] ln_q;
  logic [BYW-1:0] by_q;

  // de_o is de_i one cycle late, so it doubles as the edge-detect history
  assign vs_rise = vs_i && !vs_q;
  assign de_rise = de_i && !de_o;
  assign de_fall = !de_i && de_o;
  assign active  = (state_q == ST_ACTIVE);

  // Only lines whose de rise was seen inside ACTIVE count; the tail of a line
  // interrupted by a vs restart is ignored entirely.
  assign line_live = active && !vs_rise && (de_rise || line_ok_q);
  assign bx_room   = (bx_q < BXW'(HBLKS));
  assign px_en     = line_live && de_i && bx_room;
  assign ln_en     = active && !vs_rise && de_fall && line_ok_q;

  // px_wrap marks the last pixel of a block; add row/frame qualifiers
  assign v_hit = px_wrap && (bx_q == BXW'(HBLKS - 1)) && (ln_q == LNW'(BLK_H - 1));
  assign f_hit = v_hit && (by_q == BYW'(VBLKS - 1));

  blk_wrap_cnt #(.MAX(BLK_W), .W(PXW)) u_px (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (px_en),
    .clr   (vs_rise || de_fall),
    .q     (px_q),
    .wrap  (px_wrap)
  );

  // bx never reaches its own wrap point: it saturates at HBLKS via bx_room
  blk_wrap_cnt #(.MAX(HBLKS + 1), .W(BXW)) u_bx (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (px_wrap),
    .clr   (vs_rise || de_fall),
    .q     (bx_q),
    .wrap  (bx_wrap)
  );

  blk_wrap_cnt #(.MAX(BLK_H), .W(LNW)) u_ln (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (ln_en),
    .clr   (vs_rise),
    .q     (ln_q),
    .wrap  (ln_wrap)
  );

  blk_wrap_cnt #(.MAX(VBLKS), .W(BYW)) u_by (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (ln_wrap),
    .clr   (vs_rise),
    .q     (by_q),
    .wrap  (by_wrap)
  );

  logic unused_cnt;
  assign unused_cnt = ^{px_q, by_wrap, bx_wrap};

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: any vs edge restarts; the frame-done strobe closes ACTIVE
  always_comb begin
    state_d = state_q;
    if (vs_rise) begin
      state_d = ST_ACTIVE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_ACTIVE: if (f_pend_q) state_d = ST_DONE;
        ST_DONE:   state_d = ST_DONE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // edge history and per-line qualification flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vs_q      <= 1'b0;
      line_ok_q <= 1'b0;
    end else begin
      vs_q <= vs_i;
      if (vs_rise) begin
        line_ok_q <= 1'b0;
      end else if (de_rise) begin
        line_ok_q <= active;
      end
    end
  end

  // registered outputs: delayed pixels, strobes and clamped block indices
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      de_o         <= 1'b0;
      wd_o         <= '0;
      h_save_o     <= 1'b0;
      v_save_o     <= 1'b0;
      frame_done_o <= 1'b0;
      v_pend_q     <= 1'b0;
      f_pend_q     <= 1'b0;
      blk_x_o      <= '0;
      blk_y_o      <= '0;
    end else begin
      de_o         <= de_i;
      wd_o         <= wd_i;
      h_save_o     <= px_wrap;
      v_pend_q     <= v_hit;
      f_pend_q     <= f_hit;
      v_save_o     <= v_pend_q && !vs_rise;
      frame_done_o <= f_pend_q && !vs_rise;
      blk_x_o      <= bx_room ? bx_q[XO_W-1:0] : XO_W'(HBLKS - 1);
      blk_y_o      <= by_q;
    end
  end

  assign dbg_state_o = state_q;

`ifdef BLK_SCHED_ERR_EN
  localparam int LINE_LEN = HBLKS * BLK_W;
  localparam int LLW      = clog2_min1(LINE_LEN + 2);

  logic [LLW-1:0] llen_q;
  logic           err_q;

  // line length counter (saturating one past nominal) and sticky error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      llen_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (vs_rise || de_fall) begin
        llen_q <= '0;
      end else if (line_live && de_i && (llen_q != LLW'(LINE_LEN + 1))) begin
        llen_q <= llen_q + LLW'(1);
      end
      if ((vs_rise && active) || (ln_en && (llen_q != LLW'(LINE_LEN)))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_blk_sched.sv
// Directed bench for blk_sched with 2x2 blocks of 4x2 pixels.
module tb_blk_sched;

  localparam int HB = 2;
  localparam int VB = 2;
  localparam int BW = 4;
  localparam int BH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs  = 1'b0;
  logic        de  = 1'b0;
  logic [23:0] wd  = '0;
  logic        de_o, h_save_o, v_save_o, frame_done_o, err_o;
  logic [23:0] wd_o;
  logic [0:0]  blk_x_o, blk_y_o;
  logic [1:0]  dbg_state_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cur_line = 0;

  logic [7:0] h_q[$];
  logic [7:0] exp_q[$];
  int         h_cyc_q[$];
  int         v_cyc_q[$];
  int         fd_cyc_q[$];

  logic exp_err;

  blk_sched #(.HBLKS(HB), .VBLKS(VB), .BLK_W(BW), .BLK_H(BH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .vs_i         (vs),
    .de_i         (de),
    .wd_i         (wd),
    .de_o         (de_o),
    .wd_o         (wd_o),
    .h_save_o     (h_save_o),
    .v_save_o     (v_save_o),
    .blk_x_o      (blk_x_o),
    .blk_y_o      (blk_y_o),
    .frame_done_o (frame_done_o),
    .err_o        (err_o),
    .dbg_state_o  (dbg_state_o)
  );

  // clock
  always #5 clk = ~clk;

  // driver: apply inputs, take one edge, log strobes seen 1 time unit later
  task automatic step(input logic d, input logic v, input int pix);
    de = d;
    vs = v;
    wd = d ? {8'(cur_line), 8'(pix), 8'hA5} : 24'h0;
    @(posedge clk);
    #1;
    cyc++;
    if (h_save_o) begin
      h_q.push_back({3'(cur_line), blk_y_o, blk_x_o, 3'(pix)});
      h_cyc_q.push_back(cyc);
    end
    if (v_save_o) v_cyc_q.push_back(cyc);
    if (frame_done_o) fd_cyc_q.push_back(cyc);
  endtask

  task automatic clear_obs();
    h_q.delete();
    exp_q.delete();
    h_cyc_q.delete();
    v_cyc_q.delete();
    fd_cyc_q.delete();
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, i);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0);
    cur_line++;
  endtask

  task automatic vs_pulse();
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    rst = 1'b0;
    cur_line = 0;
    clear_obs();
  endtask

  task automatic push_exp(input int line, input int y, input int x, input int pix);
    exp_q.push_back({3'(line), 1'(y), 1'(x), 3'(pix)});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    de  = 1'b1;
    wd  = 24'h123456;
    @(posedge clk);
    #1;
    checks++; if (de_o !== 1'b0) begin failures++; $display("FAIL reset_de_o got=%b exp=0", de_o); end
    checks++; if (wd_o !== 24'h0) begin failures++; $display("FAIL reset_wd_o got=%h exp=0", wd_o); end
    checks++; if (h_save_o !== 1'b0) begin failures++; $display("FAIL reset_h_save got=%b exp=0", h_save_o); end
    checks++; if (v_save_o !== 1'b0) begin failures++; $display("FAIL reset_v_save got=%b exp=0", v_save_o); end
    checks++; if (frame_done_o !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done_o); end
    checks++; if (blk_x_o !== 1'b0 || blk_y_o !== 1'b0) begin failures++; $display("FAIL reset_blk_xy got=%b/%b exp=0/0", blk_x_o, blk_y_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
    checks++; if (dbg_state_o !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state_o); end
    de = 1'b0;
    do_reset();
  endtask

  task automatic test_frame();
    do_reset();
    vs_pulse();
    for (int l = 0; l < 4; l++) send_line(8);
    for (int l = 0; l < 4; l++) begin
      push_exp(l, l / BH, 0, 3);
      push_exp(l, l / BH, 1, 7);
    end
    checks++; if (h_q.size() !== exp_q.size()) begin failures++; $display("FAIL frame_h_count got=%0d exp=%0d", h_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < h_q.size(); i++) begin
      checks++; if (h_q[i] !== exp_q[i]) begin failures++; $display("FAIL frame_h_entry[%0d] got=%h exp=%h", i, h_q[i], exp_q[i]); end
    end
    checks++; if (v_cyc_q.size() !== 2) begin failures++; $display("FAIL frame_v_count got=%0d exp=2", v_cyc_q.size()); end
    if (v_cyc_q.size() == 2 && h_cyc_q.size() == 8) begin
      checks++; if (v_cyc_q[0] !== h_cyc_q[3] + 1) begin failures++; $display("FAIL frame_v0_cycle got=%0d exp=%0d", v_cyc_q[0], h_cyc_q[3] + 1); end
      checks++; if (v_cyc_q[1] !== h_cyc_q[7] + 1) begin failures++; $display("FAIL frame_v1_cycle got=%0d exp=%0d", v_cyc_q[1], h_cyc_q[7] + 1); end
    end
    checks++; if (fd_cyc_q.size() !== 1) begin failures++; $display("FAIL frame_done_count got=%0d exp=1", fd_cyc_q.size()); end
    if (fd_cyc_q.size() == 1 && v_cyc_q.size() == 2) begin
      checks++; if (fd_cyc_q[0] !== v_cyc_q[1]) begin failures++; $display("FAIL frame_done_cycle got=%0d exp=%0d", fd_cyc_q[0], v_cyc_q[1]); end
    end
    checks++; if (dbg_state_o !== 2'd2) begin failures++; $display("FAIL frame_state_done got=%0d exp=2", dbg_state_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL frame_err got=%b exp=0", err_o); end
  endtask

  // continues from test_frame: FSM sits in DONE
  task automatic test_done_resume();
    clear_obs();
    send_line(8);
    send_line(8);
    checks++; if (h_q.size() !== 0) begin failures++; $display("FAIL done_h_count got=%0d exp=0", h_q.size()); end
    checks++; if (v_cyc_q.size() !== 0) begin failures++; $display("FAIL done_v_count got=%0d exp=0", v_cyc_q.size()); end
    // one-cycle pixel latency holds regardless of state
    de = 1'b1;
    wd = 24'hC0FFEE;
    @(posedge clk);
    #1;
    cyc++;
    checks++; if (de_o !== 1'b1 || wd_o !== 24'hC0FFEE) begin failures++; $display("FAIL latency_pix got=%b/%h exp=1/c0ffee", de_o, wd_o); end
    de = 1'b0;
    wd = 24'h0;
    @(posedge clk);
    #1;
    cyc++;
    checks++; if (de_o !== 1'b0) begin failures++; $display("FAIL latency_de_low got=%b exp=0", de_o); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
    clear_obs();
    vs_pulse();
    send_line(8);
    push_exp(cur_line - 1, 0, 0, 3);
    push_exp(cur_line - 1, 0, 1, 7);
    checks++; if (h_q.size() !== 2) begin failures++; $display("FAIL resume_h_count got=%0d exp=2", h_q.size()); end
    for (int i = 0; i < 2 && i < h_q.size(); i++) begin
      checks++; if (h_q[i] !== exp_q[i]) begin failures++; $display("FAIL resume_h_entry[%0d] got=%h exp=%h", i, h_q[i], exp_q[i]); end
    end
    checks++; if (dbg_state_o !== 2'd1) begin failures++; $display("FAIL resume_state got=%0d exp=1", dbg_state_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL resume_err got=%b exp=0", err_o); end
  endtask

  task automatic test_long_line();
    do_reset();
    vs_pulse();
    send_line(11);
    send_line(8);
    push_exp(0, 0, 0, 3);
    push_exp(0, 0, 1, 7);
    push_exp(1, 0, 0, 3);
    push_exp(1, 0, 1, 7);
    checks++; if (h_q.size() !== 4) begin failures++; $display("FAIL long_h_count got=%0d exp=4", h_q.size()); end
    for (int i = 0; i < 4 && i < h_q.size(); i++) begin
      checks++; if (h_q[i] !== exp_q[i]) begin failures++; $display("FAIL long_h_entry[%0d] got=%h exp=%h", i, h_q[i], exp_q[i]); end
    end
    checks++; if (v_cyc_q.size() !== 1) begin failures++; $display("FAIL long_v_count got=%0d exp=1", v_cyc_q.size()); end
`ifdef BLK_SCHED_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    checks++; if (err_o !== exp_err) begin failures++; $display("FAIL long_err got=%b exp=%b", err_o, exp_err); end
  endtask

  task automatic test_short_line();
    do_reset();
    vs_pulse();
    send_line(6);
    send_line(8);
    push_exp(0, 0, 0, 3);
    push_exp(1, 0, 0, 3);
    push_exp(1, 0, 1, 7);
    checks++; if (h_q.size() !== 3) begin failures++; $display("FAIL short_h_count got=%0d exp=3", h_q.size()); end
    for (int i = 0; i < 3 && i < h_q.size(); i++) begin
      checks++; if (h_q[i] !== exp_q[i]) begin failures++; $display("FAIL short_h_entry[%0d] got=%h exp=%h", i, h_q[i], exp_q[i]); end
    end
    checks++; if (v_cyc_q.size() !== 1) begin failures++; $display("FAIL short_v_count got=%0d exp=1", v_cyc_q.size()); end
`ifdef BLK_SCHED_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    checks++; if (err_o !== exp_err) begin failures++; $display("FAIL short_err got=%b exp=%b", err_o, exp_err); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    vs_pulse();
    send_line(8);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, i);
    rst = 1'b1;
    step(1'b1, 1'b0, 5);
    checks++; if (de_o !== 1'b0 || wd_o !== 24'h0) begin failures++; $display("FAIL midrst_pix got=%b/%h exp=0/0", de_o, wd_o); end
    checks++; if (h_save_o !== 1'b0 || v_save_o !== 1'b0 || frame_done_o !== 1'b0) begin failures++; $display("FAIL midrst_strobes got=%b%b%b exp=000", h_save_o, v_save_o, frame_done_o); end
    checks++; if (blk_x_o !== 1'b0 || blk_y_o !== 1'b0 || err_o !== 1'b0) begin failures++; $display("FAIL midrst_idx got=%b/%b/%b exp=0/0/0", blk_x_o, blk_y_o, err_o); end
    checks++; if (dbg_state_o !== 2'd0) begin failures++; $display("FAIL midrst_state got=%0d exp=0", dbg_state_o); end
    rst = 1'b0;
    clear_obs();
    step(1'b1, 1'b0, 6);
    step(1'b1, 1'b0, 7);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0);
    cur_line++;
    send_line(8);
    checks++; if (h_q.size() !== 0 || v_cyc_q.size() !== 0) begin failures++; $display("FAIL midrst_quiet got=%0d/%0d exp=0/0", h_q.size(), v_cyc_q.size()); end
    clear_obs();
    vs_pulse();
    send_line(8);
    send_line(8);
    checks++; if (h_q.size() !== 4) begin failures++; $display("FAIL midrst_resume_h got=%0d exp=4", h_q.size()); end
    checks++; if (v_cyc_q.size() !== 1) begin failures++; $display("FAIL midrst_resume_v got=%0d exp=1", v_cyc_q.size()); end
    if (v_cyc_q.size() == 1 && h_cyc_q.size() == 4) begin
      checks++; if (v_cyc_q[0] !== h_cyc_q[3] + 1) begin failures++; $display("FAIL midrst_v_cycle got=%0d exp=%0d", v_cyc_q[0], h_cyc_q[3] + 1); end
    end
  endtask

  task automatic test_mid_vs();
    do_reset();
    vs_pulse();
    send_line(8);
    send_line(8);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, i);
    step(1'b1, 1'b1, 6);
    clear_obs();
    step(1'b1, 1'b0, 7);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0);
    cur_line++;
    checks++; if (h_q.size() !== 0) begin failures++; $display("FAIL midvs_tail_h got=%0d exp=0", h_q.size()); end
    send_line(8);
    checks++; if (v_cyc_q.size() !== 0) begin failures++; $display("FAIL midvs_v_after_one got=%0d exp=0", v_cyc_q.size()); end
    send_line(8);
    push_exp(3, 0, 0, 3);
    push_exp(3, 0, 1, 7);
    push_exp(4, 0, 0, 3);
    push_exp(4, 0, 1, 7);
    checks++; if (h_q.size() !== 4) begin failures++; $display("FAIL midvs_h_count got=%0d exp=4", h_q.size()); end
    for (int i = 0; i < 4 && i < h_q.size(); i++) begin
      checks++; if (h_q[i] !== exp_q[i]) begin failures++; $display("FAIL midvs_h_entry[%0d] got=%h exp=%h", i, h_q[i], exp_q[i]); end
    end
    checks++; if (v_cyc_q.size() !== 1) begin failures++; $display("FAIL midvs_v_after_two got=%0d exp=1", v_cyc_q.size()); end
    if (v_cyc_q.size() == 1 && h_cyc_q.size() == 4) begin
      checks++; if (v_cyc_q[0] !== h_cyc_q[3] + 1) begin failures++; $display("FAIL midvs_v_cycle got=%0d exp=%0d", v_cyc_q[0], h_cyc_q[3] + 1); end
    end
    checks++; if (fd_cyc_q.size() !== 0) begin failures++; $display("FAIL midvs_frame_done got=%0d exp=0", fd_cyc_q.size()); end
`ifdef BLK_SCHED_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    checks++; if (err_o !== exp_err) begin failures++; $display("FAIL midvs_err got=%b exp=%b", err_o, exp_err); end
  endtask

  initial begin
    #1;
    test_reset();
    test_frame();
    test_done_resume();
    test_long_line();
    test_short_line();
    test_mid_reset();
    test_mid_vs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
